// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words and expands LI into LUI/ADDI.
// One registered output word with valid/ready on both sides; up to one word per cycle.
module instr_encoder #(
    parameter bit         CHECK_IMM = 1'b1,
    parameter logic [2:0] FMT_I     = 3'd1,
    parameter logic [2:0] FMT_S     = 3'd2,
    parameter logic [2:0] FMT_B     = 3'd3,
    parameter logic [2:0] FMT_U     = 3'd4,
    parameter logic [2:0] FMT_J     = 3'd5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_fmt_i,
    input  logic [6:0]  req_opcode_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [6:0]  req_funct7_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [31:0] req_imm_i,
    input  logic        req_li_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_err_o,
    output logic        instr_last_o,
    output logic        dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // A producer holds valid and its payload stable until that transfer occurs.

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_EMIT2 = 1'b1
    } state_t;

    state_t state, state_nx;

    logic        free;
    logic        accept;
    logic signed [31:0] simm;
    logic        fits12;
    logic        is_shift;
    logic [11:0] i_imm;
    logic [11:0] li_lo;
    logic [19:0] li_hi;

    logic [31:0] enc_word;
    logic        enc_err;
    logic        enc_last;
    logic        enc_two;

    logic        load;
    logic [31:0] load_word;
    logic        load_err;
    logic        load_last;

    logic [4:0]  pend_rd;
    logic [11:0] pend_lo;

    assign free        = !instr_valid_o || instr_ready_i;
    assign req_ready_o = (state == S_IDLE) && free;
    assign accept      = req_valid_i && req_ready_o;
    assign dbg_state_o = (state == S_EMIT2);

    assign simm     = req_imm_i;
    assign fits12   = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign is_shift = (req_opcode_i == OP_IMM) &&
                      ((req_funct3_i == 3'b001) || (req_funct3_i == 3'b101));
    assign i_imm    = req_imm_i[11:0] | (is_shift ? {req_funct7_i, 5'd0} : 12'd0);

    // ADDI sign-extends lo, so the upper part is rounded up whenever lo is negative.
    assign li_lo = req_imm_i[11:0];
    assign li_hi = req_imm_i[31:12] + {19'd0, req_imm_i[11]};

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        enc_last = 1'b1;
        enc_two  = 1'b0;
        if (req_li_i) begin
            if (fits12) begin
                enc_word = {li_lo, 5'd0, 3'b000, req_rd_i, OP_IMM};
            end else begin
                enc_word = {li_hi, req_rd_i, OP_LUI};
                enc_last = (li_lo == 12'd0);
                enc_two  = (li_lo != 12'd0);
            end
        end else begin
            case (req_fmt_i)
                FMT_I: begin
                    enc_word = {i_imm, req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
                    enc_err  = is_shift ? (req_imm_i[31:5] != 27'd0) : !fits12;
                end
                FMT_S: begin
                    enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                                req_imm_i[4:0], req_opcode_i};
                    enc_err  = !fits12;
                end
                FMT_B: begin
                    enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i,
                                req_funct3_i, req_imm_i[4:1], req_imm_i[11], req_opcode_i};
                    enc_err  = req_imm_i[0] || (simm < -32'sd4096) || (simm > 32'sd4094);
                end
                FMT_U: begin
                    enc_word = {req_imm_i[31:12], req_rd_i, req_opcode_i};
                    enc_err  = (req_imm_i[11:0] != 12'd0);
                end
                FMT_J: begin
                    enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11],
                                req_imm_i[19:12], req_rd_i, req_opcode_i};
                    enc_err  = req_imm_i[0] || (simm < -32'sd1048576) ||
                               (simm > 32'sd1048574);
                end
                default: begin
                    enc_word = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i,
                                req_rd_i, req_opcode_i};
                end
            endcase
        end
        if (!CHECK_IMM) begin
            enc_err = 1'b0;
        end
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        load_word = enc_word;
        load_err  = enc_err;
        load_last = enc_last;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (enc_two) begin
                        state_nx = S_EMIT2;
                    end
                end
            end
            S_EMIT2: begin
                // Request inputs are ignored here; the ADDI comes from the latched rd/lo.
                if (free) begin
                    load      = 1'b1;
                    load_word = {pend_lo, pend_rd, 3'b000, pend_rd, OP_IMM};
                    load_err  = 1'b0;
                    load_last = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            pend_rd <= '0;
            pend_lo <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                pend_rd <= req_rd_i;
                pend_lo <= li_lo;
            end
        end
    end

    // Loading while the old word is consumed replaces it without a valid bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_err_o   <= 1'b0;
            instr_last_o  <= 1'b0;
        end else if (load) begin
            instr_valid_o <= 1'b1;
            instr_o       <= load_word;
            instr_err_o   <= load_err;
            instr_last_o  <= load_last;
        end else if (instr_ready_i) begin
            instr_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases plus randomized requests checked against a field-level
// model through an expected-word queue consumed by an independent output monitor.
module tb_instr_encoder;

    localparam int W = 34;
    localparam logic [2:0] F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;
    localparam logic [2:0] F_R = 3'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_fmt = '0;
    logic [6:0]  req_opcode = '0;
    logic [2:0]  req_funct3 = '0;
    logic [6:0]  req_funct7 = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        req_li = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic        instr_err;
    logic        instr_last;
    logic        dbg_state;

    instr_encoder #(.CHECK_IMM(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_fmt_i(req_fmt), .req_opcode_i(req_opcode), .req_funct3_i(req_funct3),
        .req_funct7_i(req_funct7), .req_rd_i(req_rd), .req_rs1_i(req_rs1),
        .req_rs2_i(req_rs2), .req_imm_i(req_imm), .req_li_i(req_li),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .instr_err_o(instr_err), .instr_last_o(instr_last),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cons_mode = 0;   // 0: always ready, 1: random, 2: held by directed code
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fld(input logic [31:0] v, input int lsb, input int width,
                                        input int pos);
        logic [31:0] m;
        m = (32'd1 << width) - 32'd1;
        return ((v >> lsb) & m) << pos;
    endfunction

    function automatic void model(input logic [2:0] fmt, input logic [6:0] op,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm,
                                  input logic li);
        int          s;
        int          lo;
        logic [31:0] w;
        logic [31:0] d;
        logic [31:0] regs;
        logic        err;
        bit          shift;
        s    = imm;
        regs = (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20);
        if (li) begin
            lo = s & 'hFFF;
            if (lo >= 2048) lo -= 4096;
            if (s >= -2048 && s <= 2047) begin
                exp_q.push_back({1'b0, 1'b1, (32'(lo) << 20) | (32'(rd) << 7) | 32'h13});
            end else begin
                d = imm - 32'(lo);   // upper part such that (hi<<12)+lo == imm
                exp_q.push_back({1'b0, (lo == 0), (d & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37});
                if (lo != 0)
                    exp_q.push_back({1'b0, 1'b1, (32'(lo) << 20) | (32'(rd) << 15) |
                                                 (32'(rd) << 7) | 32'h13});
            end
            return;
        end
        err = 1'b0;
        case (fmt)
            F_I: begin
                shift = (op == 7'h13) && (f3 == 3'b001 || f3 == 3'b101);
                w = fld(imm, 0, 12, 20) | regs & 32'h000FFF80 | 32'(op);
                w = (fld(imm, 0, 12, 20) | (shift ? 32'(f7) << 25 : 32'd0)) |
                    (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
                err = shift ? (imm >= 32) : (s < -2048 || s > 2047);
            end
            F_S: begin
                w = fld(imm, 5, 7, 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                    (32'(f3) << 12) | fld(imm, 0, 5, 7) | 32'(op);
                err = (s < -2048 || s > 2047);
            end
            F_B: begin
                w = fld(imm, 12, 1, 31) | fld(imm, 5, 6, 25) | (32'(rs2) << 20) |
                    (32'(rs1) << 15) | (32'(f3) << 12) | fld(imm, 1, 4, 8) |
                    fld(imm, 11, 1, 7) | 32'(op);
                err = (s % 2 != 0) || s < -4096 || s > 4094;
            end
            F_U: begin
                w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
                err = (imm % 4096) != 0;
            end
            F_J: begin
                w = fld(imm, 20, 1, 31) | fld(imm, 1, 10, 21) | fld(imm, 11, 1, 20) |
                    fld(imm, 12, 8, 12) | (32'(rd) << 7) | 32'(op);
                err = (s % 2 != 0) || s < -1048576 || s > 1048574;
            end
            default: begin
                w = (32'(f7) << 25) | regs | 32'(op);
            end
        endcase
        exp_q.push_back({err, 1'b1, w});
    endfunction

    // ---------------- driver tasks (start and end at posedge+1) ----------------
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic li,
                        output int waits);
        req_fmt = fmt; req_opcode = op; req_funct3 = f3; req_funct7 = f7;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_li = li;
        req_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waits++;
            if (waits > 200) begin
                check("req_accept_timeout", 64'(waits), 64'd0);
                break;
            end
        end
        if (req_ready) model(fmt, op, f3, f7, rd, rs1, rs2, imm, li);
        @(posedge clk); #1;
    endtask

    // Deassert valid and scramble fields so a stray sample of them would corrupt output.
    task automatic idle(input int cycles);
        req_valid = 1'b0;
        req_imm = $urandom; req_rd = 5'($urandom); req_li = 1'($urandom);
        req_fmt = 3'($urandom); req_opcode = 7'($urandom);
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || instr_valid) && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_imm();
        int bnd[15] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
                        1048574, -1048576, 1048576, 0, 1, 31, 32};
        case ($urandom_range(0, 5))
            0: return 32'(int'($urandom_range(0, 4095)) - 2048);
            1: return 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            2: return 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFFFFFE;
            3: return $urandom & 32'hFFFFF000;
            4: return bnd[$urandom_range(0, 14)];
            default: return $urandom;
        endcase
    endfunction

    // ---------------- consumer ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            if (cons_mode == 0) instr_ready = 1'b1;
            else if (cons_mode == 1) instr_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] got;
        logic [W-1:0] prev;
        logic [W-1:0] e;
        bit           prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            got = {instr_err, instr_last, instr};
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(instr_valid), 64'd1);
                    check("hold_word", 64'(got), 64'(prev));
                end
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 64'(got), 64'h3_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_word", 64'(got), 64'(e));
                    end
                end
                prev_stall = instr_valid && !instr_ready;
                prev = got;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int seen;
        logic [2:0] fmt;
        logic [6:0] op;
        logic [2:0] f3;
        #2;
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_err_last", 64'({instr_err, instr_last}), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ADDI x1,x2,-1: visible in the cycle after acceptance
        send(F_I, 7'h13, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0, w);
        check("addi_latency_valid", 64'(instr_valid), 64'd1);
        check("addi_word", 64'(instr), 64'hFFF10093);
        check("addi_err_last", 64'({instr_err, instr_last}), 64'b01);

        // LI x5,0x12345FFF: two words, request port closed between them
        send(F_R, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 1'b1, w);
        check("li2_lui_word", 64'(instr), 64'h123462B7);
        check("li2_ready_gap", 64'(req_ready), 64'd0);
        idle(1);
        check("li2_addi_word", 64'(instr), 64'hFFF28293);
        wait_drain();

        // single-word LI cases and BEQ with/without misalignment, back to back
        send(F_R, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, w);
        check("li_lui_only", 64'({instr_last, instr}), {31'd0, 1'b1, 32'h123452B7});
        send(F_R, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFB, 1'b1, w);
        check("b2b_no_wait", 64'(w), 64'd0);
        check("li_small", 64'(instr), 64'hFFB00293);
        send(F_B, 7'h63, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, w);
        check("beq_word", 64'({instr_err, instr}), {32'd0, 1'b0, 32'h00208463});
        send(F_B, 7'h63, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, w);
        check("beq_misaligned_err", 64'(instr_err), 64'd1);
        idle(1);
        wait_drain();

        // backpressure for 3 cycles on the two-word LI
        cons_mode = 2; instr_ready = 1'b0;
        send(F_R, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 1'b1, w);
        idle(3);
        check("bp_ready_low", 64'(req_ready), 64'd0);
        check("bp_still_lui", 64'(instr), 64'h123462B7);
        cons_mode = 0;
        wait_drain();

        // reset right after the LUI handshake: ADDI must never appear
        cons_mode = 2; instr_ready = 1'b0;
        send(F_R, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 1'b1, w);
        idle(0);
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(instr_valid), 64'd0);
        check("rst_mid_instr", 64'(instr), 64'd0);
        check("rst_mid_state", 64'(dbg_state), 64'd0);
        exp_q.delete();
        cons_mode = 0;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (5) begin @(negedge clk); if (instr_valid) seen++; end
        check("rst_no_addi", 64'(seen), 64'd0);
        check("rst_release_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // randomized traffic with random consumer stalls
        cons_mode = 1;
        for (int i = 0; i < 400; i++) begin
            fmt = 3'($urandom_range(0, 7));
            op  = ($urandom_range(0, 3) == 0) ? 7'h13 : 7'($urandom);
            f3  = 3'($urandom);
            send(fmt, op, f3, ($urandom_range(0, 1) == 0) ? 7'h20 : 7'($urandom),
                 5'($urandom), 5'($urandom), 5'($urandom),
                 ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 40)) : rand_imm(),
                 1'($urandom_range(0, 3) == 0), w);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        cons_mode = 0;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
